// File: rtl/pulse_req_arb.sv
// Round-robin arbiter that turns level-request rising edges into single
// launches of a shared resource, with completion ack, WAIT timeout and lost-edge detection.
module pulse_req_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_in,
  input  logic            res_done,
  output logic [NREQ-1:0] grant,
  output logic            start,
  output logic [NREQ-1:0] ack,
  output logic            timeout,
  output logic            overrun
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [7:0]      TMAX     = 8'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] ZERO     = {NREQ{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      timer_q, timer_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;

  logic [NREQ-1:0] rise_s;
  logic [NREQ-1:0] clr_s;
  logic [IW-1:0]   rr_idx_s;
  logic [IW-1:0]   win_s;
  logic            found_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = ONE << idx;
  endfunction

  // State, request history, pending set and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= ZERO;
      pending_q <= ZERO;
      last_q    <= LAST_RST;
      timer_q   <= 8'd0;
      grant_q   <= ZERO;
      start_q   <= 1'b0;
      ack_q     <= ZERO;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_in;
      pending_q <= pending_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // Round-robin search starting one past the previous winner
  always_comb begin
    found_s  = 1'b0;
    win_s    = last_q;
    rr_idx_s = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx_s = IW'((int'(last_q) + k) % NREQ);
      win_s    = (!found_s && pending_q[rr_idx_s]) ? rr_idx_s : win_s;
      found_s  = found_s | pending_q[rr_idx_s];
    end
  end

  // Edge capture: a new rise beats the clear of the same bit
  always_comb begin
    rise_s    = req_in & ~req_q;
    clr_s     = (state_q == S_IDLE && found_s) ? onehot(win_s) : ZERO;
    pending_d = (pending_q & ~clr_s) | rise_s;
    overrun_d = |(rise_s & pending_q & ~clr_s);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_START;
          last_d  = win_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_done || timer_q == TMAX) begin
          state_d = S_RELEASE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode, one cycle ahead of the registers
  always_comb begin
    grant_d   = (state_d == S_START || state_d == S_WAIT) ? onehot(last_d) : ZERO;
    start_d   = (state_d == S_START);
    ack_d     = (state_q == S_WAIT && res_done) ? onehot(last_q) : ZERO;
    timeout_d = (state_q == S_WAIT) && !res_done && (timer_q == TMAX);
  end

  assign grant   = grant_q;
  assign start   = start_q;
  assign ack     = ack_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule
